fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO, in the rclk domain. Pops DSIZE-bit words from the
//  FIFO read port (rempty/rinc/rdata) and packs NWORDS consecutive words into one wide beat.
//  Presents each beat on a valid/ready stream to downstream logic.
//  Supports explicit flush of a partial beat.
// PARAMETERS
//  DSIZE    8   FIFO word width; matches the FIFO DSIZE
//  NWORDS   4   words per output beat; >=2
//  TIMEOUT  16  idle cycles before auto-flush; >=2; used only with FIFO_RD_PACK_TIMEOUT_EN
// PORTS
//  rclk       in   1                   read-domain clock, all logic on posedge
//  rrst_n     in   1                   asynchronous active-low reset
//  rempty     in   1                   FIFO empty flag
//  rdata      in   DSIZE               FIFO read data, valid in the same cycle whenever rempty=0
//  rinc       out  1                   pop strobe to FIFO; one word consumed per cycle high
//  flush      in   1                   request emission of a partial beat
//  out_data   out  DSIZE*NWORDS        packed beat; word k in bits [k*DSIZE +: DSIZE]
//  out_nvalid out  $clog2(NWORDS+1)    count of valid words in beat (1..NWORDS)
//  out_valid  out  1                   beat valid
//  out_ready  in   1                   downstream accepts beat when out_valid&&out_ready
// BEHAVIOUR
//  - State: accumulator acc[DSIZE*NWORDS], lane count cnt (0..NWORDS-1), flush_pend,
//    output register (out_data/out_nvalid/out_valid).
//  - Reset (rrst_n=0, async): cnt=0, acc=0, flush_pend=0, out_valid=0, out_data=0,
//    out_nvalid=0. rinc is forced to 0 while rrst_n=0.
//  - Reset asserted mid-packing discards the partial accumulator and any held beat.
//  - obuf_free = !out_valid || out_ready.
//  - rinc = !rempty && (cnt!=NWORDS-1 || obuf_free). This is combinational with no pop
//    when the FIFO is empty. A completing word stalls only when the output register is
//    occupied and not draining.
//  - Accept (rinc=1): rdata is written to lane cnt.
//    - If cnt<NWORDS-1: cnt increments.
//    - If cnt==NWORDS-1: {rdata, acc lanes} is loaded into the output register with
//      out_nvalid=NWORDS, out_valid=1 next cycle, then cnt=0 and acc=0.
//  - Latency: completing pop at cycle N gives out_valid=1 at N+1.
//  - Back-to-back full beats sustain 1 word/cycle while out_ready=1.
//  - Flush: a flush pulse sets flush_pend when cnt>0 or a word is accepted the same cycle.
//    A flush with cnt==0 and no accept is ignored.
//    - flush_pend is served when obuf_free: beat = acc lanes 0..cnt-1, unused lanes zero,
//      out_nvalid=cnt. Then cnt=0, acc=0, flush_pend=0.
//    - If an accept occurs in the serving cycle, the accepted word is included and
//      out_nvalid=cnt+1. Words accepted while the flush is pending are also included.
//    - If that accept completes the beat (cnt+1==NWORDS), it is a normal full beat and
//      flush_pend clears.
//    - While flush_pend=1 and !obuf_free, pops continue until cnt==NWORDS-1 (normal stall).
//  - The output register is held stable while out_valid && !out_ready.
//  - out_valid drops the cycle after a handshake unless a new beat loads in the same cycle.
// CONFIGURATION
//  FIFO_RD_PACK_TIMEOUT_EN defined:
//    - idle counter clears on reset, on any accept, and whenever cnt==0.
//    - Otherwise it increments each cycle and saturates at TIMEOUT-1.
//    - At TIMEOUT-1 it raises an internal flush, identical to a flush pulse.
//    - A partial beat therefore leaves no later than TIMEOUT cycles after its last pop,
//      provided the output register is free.
//  Not defined: no idle counter, no TIMEOUT logic. Partial beats leave only on flush.
// TESTING
//  1. Reset with FIFO holding 8 words, out_ready=1, NWORDS=4:
//     rinc=1 for 8 cycles; beats 0x03020100 then 0x07060504, both with out_nvalid=4.
//  2. out_ready=0 with 12 words queued:
//     rinc stops after 7 pops (1 beat held + 3 lanes). Raising out_ready resumes at
//     1 word/cycle with no data loss or duplication.
//  3. Pop 0xAA,0xBB then flush=1 for 1 cycle:
//     beat 0x0000BBAA with out_nvalid=2 next cycle; a flush with cnt==0 emits nothing.
//  4. flush in the same cycle as the 3rd pop gives out_nvalid=3.
//     flush in the same cycle as the 4th pop gives one full beat, with no extra empty beat.
//  5. Assert rrst_n=0 asynchronously with cnt=2 and out_valid=1:
//     all outputs zero immediately. After release, the next 4 pops form a clean beat.
//  6. With FIFO_RD_PACK_TIMEOUT_EN, TIMEOUT=16: pop 1 word then FIFO goes empty.
//     Beat with out_nvalid=1 appears within 16 cycles; none appears without the macro.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Read-side bundle for fifo_rd_packer: FIFO pop port plus the packed-beat valid/ready stream.
// slave = the packer, master = whoever owns the FIFO word source and the beat sink.
interface fifo_rd_packer_if #(
    parameter int DSIZE  = 8,
    parameter int NWORDS = 4
);
    localparam int NVW = $clog2(NWORDS + 1);

    logic                    rempty;
    logic [DSIZE-1:0]        rdata;
    logic                    rinc;
    logic                    flush;
    logic [DSIZE*NWORDS-1:0] out_data;
    logic [NVW-1:0]          out_nvalid;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  rempty, rdata, flush, out_ready,
        output rinc, out_data, out_nvalid, out_valid
    );

    modport master (
        output rempty, rdata, flush, out_ready,
        input  rinc, out_data, out_nvalid, out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops DSIZE-bit words from the async FIFO read port and packs NWORDS of them into one beat.
// Optional idle auto-flush is compiled in with FIFO_RD_PACK_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int NWORDS  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            rclk,
    input  logic            rrst_n,
    fifo_rd_packer_if.slave bus
);
    localparam int CW  = $clog2(NWORDS);
    localparam int NVW = $clog2(NWORDS + 1);
    localparam int BW  = DSIZE * NWORDS;
    localparam logic [CW-1:0] LAST_LANE = CW'(NWORDS - 1);

    if (NWORDS < 2 || TIMEOUT < 2) begin : g_param_check
        $error("fifo_rd_packer: NWORDS and TIMEOUT must both be at least 2");
    end

    logic [BW-1:0]  acc_q, acc_d, acc_ins_s;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NVW-1:0] cnt_ins_s;
    logic           flush_pend_q, flush_pend_d;
    logic [BW-1:0]  out_data_q, out_data_d;
    logic [NVW-1:0] out_nvalid_q, out_nvalid_d;
    logic           out_valid_q, out_valid_d;
    logic           obuf_free_s, accept_s, complete_s;
    logic           timeout_s, flush_req_s, pend_s, serve_s;

    // Pop decision: only a beat-completing word waits for the output register.
    always_comb begin
        obuf_free_s = !out_valid_q || bus.out_ready;
        if (rrst_n && !bus.rempty) begin
            accept_s = (cnt_q != LAST_LANE) || obuf_free_s;
        end else begin
            accept_s = 1'b0;
        end
        complete_s = accept_s && (cnt_q == LAST_LANE);
    end

    assign bus.rinc = accept_s;

    // Accumulator view with this cycle's word already merged into lane cnt.
    always_comb begin
        acc_ins_s = acc_q;
        if (accept_s) begin
            acc_ins_s[int'(cnt_q) * DSIZE +: DSIZE] = bus.rdata;
        end else begin
            acc_ins_s = acc_q;
        end
        cnt_ins_s = NVW'(cnt_q) + NVW'(accept_s);
    end

    // A flush request only latches when there is at least one word to emit.
    always_comb begin
        flush_req_s = bus.flush || timeout_s;
        if (flush_req_s && ((cnt_q != {CW{1'b0}}) || accept_s)) begin
            pend_s = 1'b1;
        end else begin
            pend_s = flush_pend_q;
        end
        serve_s = pend_s && obuf_free_s && !complete_s;
    end

    // Next state: a full beat or a served flush loads the output register and clears packing.
    always_comb begin
        acc_d        = acc_ins_s;
        cnt_d        = cnt_ins_s[CW-1:0];
        flush_pend_d = pend_s;
        out_data_d   = out_data_q;
        out_nvalid_d = out_nvalid_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        if (complete_s || serve_s) begin
            out_data_d   = acc_ins_s;
            out_nvalid_d = cnt_ins_s;
            out_valid_d  = 1'b1;
            acc_d        = {BW{1'b0}};
            cnt_d        = {CW{1'b0}};
            flush_pend_d = 1'b0;
        end else begin
            acc_d        = acc_ins_s;
            cnt_d        = cnt_ins_s[CW-1:0];
        end
    end

    // State and output registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc_q        <= {BW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            flush_pend_q <= 1'b0;
            out_data_q   <= {BW{1'b0}};
            out_nvalid_q <= {NVW{1'b0}};
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_nvalid_q <= out_nvalid_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_nvalid = out_nvalid_q;
    assign bus.out_valid  = out_valid_q;

`ifdef FIFO_RD_PACK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_q, idle_d;

    // Idle counter runs only while a partial beat sits without new words.
    always_comb begin
        if (accept_s || (cnt_q == {CW{1'b0}})) begin
            idle_d = {IW{1'b0}};
        end else if (idle_q == IDLE_MAX) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            idle_q <= {IW{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end

    assign timeout_s = (idle_q == IDLE_MAX);
`else
    assign timeout_s = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed + randomized bench for fifo_rd_packer against a word-queue reference model.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int NW = 4;
    localparam int TO = 16;
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fifo_rd_packer_if #(.DSIZE(DW), .NWORDS(NW)) bus ();

    fifo_rd_packer #(.DSIZE(DW), .NWORDS(NW), .TIMEOUT(TO)) dut (
        .rclk   (clk),
        .rrst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  pushed_q[$];
    logic [7:0]  recv_q[$];
    logic [31:0] beat_data_q[$];
    int          beat_n_q[$];

    // Reference model: words collected so far, plus the presented beat.
    logic [7:0]  m_words[$];
    logic        m_valid;
    logic [31:0] m_data;
    int          m_n;
    bit          m_pend;
    int          m_idle;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_n     = 0;
        m_pend  = 1'b0;
        m_idle  = 0;
    endtask

    task automatic drive_fifo();
        bus.rempty = (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        pushed_q.push_back(w);
        drive_fifo();
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_count"}, recv_q.size(), pushed_q.size());
        for (int i = 0; i < recv_q.size() && i < pushed_q.size(); i++) begin
            chk({tag, "_word"}, recv_q[i], pushed_q[i]);
        end
        recv_q.delete();
        pushed_q.delete();
    endtask

    // One clock cycle: check DUT against the model, then advance the model by the rules.
    task automatic tick();
        bit exp_rinc, free, had, fl, popped;
        drive_fifo();
        @(negedge clk);
        exp_rinc = rst_n && (fifo_q.size() > 0) &&
                   ((m_words.size() != NW - 1) || !m_valid || bus.out_ready);
        chk("rinc", bus.rinc, exp_rinc);
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data", bus.out_data, m_data);
        chk("out_nvalid", bus.out_nvalid, m_n);
        popped = bus.rinc;
        if (popped) pops++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            beat_data_q.push_back(bus.out_data);
            beat_n_q.push_back(int'(bus.out_nvalid));
            for (int k = 0; k < int'(bus.out_nvalid) && k < NW; k++) begin
                recv_q.push_back(bus.out_data[k*8 +: 8]);
            end
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            free = !m_valid || bus.out_ready;
            had  = (m_words.size() > 0);
            fl   = bus.flush || (TOEN && (m_idle == TO - 1));
            if (exp_rinc) m_words.push_back(fifo_q[0]);
            if (exp_rinc || !had) m_idle = 0;
            else if (m_idle < TO - 1) m_idle++;
            if (fl && (had || exp_rinc)) m_pend = 1'b1;
            if (m_valid && bus.out_ready) m_valid = 1'b0;
            if ((m_words.size() == NW) || (m_pend && free && (m_words.size() > 0))) begin
                m_data = 32'h0;
                foreach (m_words[k]) m_data[k*8 +: 8] = m_words[k];
                m_n     = m_words.size();
                m_valid = 1'b1;
                m_pend  = 1'b0;
                m_words.delete();
            end
        end
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        bus.flush = 1'b0;
        drive_fifo();
    endtask

    initial begin
        int n0;
        int cyc;
        bit seen;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        drive_fifo();

        // Reset state.
        tick();
        tick();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_nvalid", bus.out_nvalid, 3'd0);
        rst_n = 1'b1;

        // Two full beats back to back.
        for (int i = 0; i < 8; i++) push(8'(i));
        pops = 0;
        beat_data_q.delete();
        beat_n_q.delete();
        repeat (11) tick();
        chk("t1_pops", pops, 8);
        chk("t1_beats", beat_data_q.size(), 2);
        if (beat_data_q.size() >= 2) begin
            chk("t1_beat0", beat_data_q[0], 32'h03020100);
            chk("t1_n0", beat_n_q[0], 4);
            chk("t1_beat1", beat_data_q[1], 32'h07060504);
            chk("t1_n1", beat_n_q[1], 4);
        end

        // Backpressure: one beat held plus three lanes, then resume.
        bus.out_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
        repeat (12) tick();
        chk("t2_stall_pops", pops, 7);
        bus.out_ready = 1'b1;
        repeat (12) tick();
        chk("t2_drained", fifo_q.size(), 0);
        cmp_logs("t2");

        // Flush of a two-word partial beat; flush with nothing packed is ignored.
        push(8'hAA);
        push(8'hBB);
        repeat (3) tick();
        bus.flush = 1'b1;
        tick();
        chk("t3_valid", bus.out_valid, 1'b1);
        chk("t3_data", bus.out_data, 32'h0000BBAA);
        chk("t3_nvalid", bus.out_nvalid, 3'd2);
        tick();
        n0 = beat_data_q.size();
        bus.flush = 1'b1;
        tick();
        tick();
        chk("t3_empty_flush", bus.out_valid, 1'b0);
        chk("t3_no_beat", beat_data_q.size(), n0);

        // Flush coinciding with the 3rd pop, then with the 4th pop.
        push(8'hC1); push(8'hC2); push(8'hC3);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        chk("t4a_valid", bus.out_valid, 1'b1);
        chk("t4a_data", bus.out_data, 32'h00C3C2C1);
        chk("t4a_nvalid", bus.out_nvalid, 3'd3);
        tick();
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        repeat (3) tick();
        bus.flush = 1'b1;
        tick();
        chk("t4b_data", bus.out_data, 32'hD4D3D2D1);
        chk("t4b_nvalid", bus.out_nvalid, 3'd4);
        n0 = beat_data_q.size();
        tick();
        tick();
        chk("t4b_no_extra", bus.out_valid, 1'b0);
        chk("t4b_one_beat", beat_data_q.size(), n0 + 1);
        cmp_logs("t34");

        // Asynchronous reset with a held beat and two packed lanes.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        repeat (6) tick();
        chk("t5_held", bus.out_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rinc", bus.rinc, 1'b0);
        chk("t5_valid", bus.out_valid, 1'b0);
        chk("t5_data", bus.out_data, 32'h0);
        chk("t5_nvalid", bus.out_nvalid, 3'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        pushed_q.delete();
        recv_q.delete();
        chk("t5_fifo_used", fifo_q.size(), 0);
        bus.out_ready = 1'b1;
        push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
        repeat (4) tick();
        chk("t5_clean_valid", bus.out_valid, 1'b1);
        chk("t5_clean_data", bus.out_data, 32'hE3E2E1E0);
        chk("t5_clean_nvalid", bus.out_nvalid, 3'd4);
        tick();
        cmp_logs("t5");

        // Lone word with the FIFO running dry: auto-flush only when the timeout is built in.
        push(8'h5A);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < TO + 4; i++) begin
            tick();
            if (!seen && bus.out_valid) begin
                seen = 1'b1;
                cyc  = i;
                chk("t6_nvalid", bus.out_nvalid, 3'd1);
            end
        end
        chk("t6_auto_beat", seen, TOEN);
        if (seen) chk("t6_latency", (cyc <= TO), 1'b1);
        if (!seen) begin
            bus.flush = 1'b1;
            tick();
            tick();
        end
        cmp_logs("t6");

        // Random traffic, backpressure and flushes.
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            n0 = int'($urandom_range(0, 2));
            for (int j = 0; j < n0; j++) begin
                if (fifo_q.size() < 16) push(8'($urandom));
            end
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (30) tick();
        bus.flush = 1'b1;
        tick();
        repeat (3) tick();
        chk("rand_drained", fifo_q.size(), 0);
        cmp_logs("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
